// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline sequencing controller:
// next-PC source codes, exception handler address and mult/div latencies.
package pipe_seq_ctrl_pkg;

    localparam logic [1:0] PCSEL_SEQ     = 2'd0;
    localparam logic [1:0] PCSEL_HANDLER = 2'd1;
    localparam logic [1:0] PCSEL_EPC     = 2'd2;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int MD_CNT_W     = 4;

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_EXL    = 1'b1
    } mode_e;

endpackage

// File: rtl/pipe_seq_ctrl_md_busy_cnt.sv
// Mult/div occupancy counter: loads the unit latency on an accepted issue and
// counts down to zero; busy is simply "counter nonzero".
module md_busy_cnt
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_LAT);
    localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_LAT);
    localparam logic [MD_CNT_W-1:0] CNT_ONE = MD_CNT_W'(1);

    logic [MD_CNT_W-1:0] cnt_q;
    logic [MD_CNT_W-1:0] cnt_d;

    // An issue while the counter is running is dropped; the running op finishes.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d (no latch).
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (md_start) begin
            cnt_d = md_is_div ? DIV_LD : MULT_LD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: stall/bubble generation, exception/interrupt
// redirect and the NORMAL/EXL mode bit.
module pipe_seq_ctrl
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hz_stall,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic       md_use_d,
    input  logic       exc_req,
    input  logic       int_req,
    input  logic       eret_m,
    output logic       f_en,
    output logic       d_en,
    output logic       e_clr,
    output logic       req,
    output logic [1:0] pc_sel,
    output logic       md_busy,
    output logic       exl
);

    mode_e mode_q;
    logic  take;
    logic  stall;

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_busy   (md_busy)
    );

    // A redirect outranks ERET; an exception in EXL re-enters the handler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_NORMAL;
        end else if (take) begin
            mode_q <= MODE_EXL;
        end else if (eret_m) begin
            mode_q <= MODE_NORMAL;
        end
    end

    assign exl  = (mode_q == MODE_EXL);
    assign take = exc_req | (int_req & ~exl);

    // The redirect is held off while reset is asserted.
    assign req   = take & reset;
    assign stall = hz_stall | (md_use_d & (md_busy | md_start));

    // req flushes every stage register, so it overrides any stall.
    assign f_en  = req | ~stall;
    assign d_en  = req | ~stall;
    assign e_clr = stall & ~req;

    always_comb begin
        pc_sel = PCSEL_SEQ;
        if (reset) begin
            if (take) begin
                pc_sel = PCSEL_HANDLER;
            end else if (eret_m) begin
                pc_sel = PCSEL_EPC;
            end
        end
    end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: a cycle-indexed behavioural model
// checked every negedge, plus directed scenarios with literal expectations.
module tb_pipe_seq_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic       clk;
    logic       reset;
    logic       hz_stall, md_start, md_is_div, md_use_d;
    logic       exc_req, int_req, eret_m;
    logic       f_en, d_en, e_clr, req, md_busy, exl;
    logic [1:0] pc_sel;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_seq_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hz_stall  (hz_stall),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_use_d  (md_use_d),
        .exc_req   (exc_req),
        .int_req   (int_req),
        .eret_m    (eret_m),
        .f_en      (f_en),
        .d_en      (d_en),
        .e_clr     (e_clr),
        .req       (req),
        .pc_sel    (pc_sel),
        .md_busy   (md_busy),
        .exl       (exl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the unit is busy for the cycle indices (cyc, busy_until];
    // a start is accepted only when the unit is idle.
    int cyc        = 0;
    int busy_until = -1;
    bit m_exl      = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc        = 0;
            busy_until = -1;
            m_exl      = 1'b0;
        end else begin
            if (md_start && !(cyc <= busy_until))
                busy_until = cyc + (md_is_div ? DIV_LAT : MULT_LAT);
            if (exc_req || (int_req && !m_exl))
                m_exl = 1'b1;
            else if (eret_m)
                m_exl = 1'b0;
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        bit e_busy, e_take, e_req, e_stall;
        logic [1:0] e_pc;
        e_busy  = reset && (cyc <= busy_until);
        e_take  = exc_req || (int_req && !m_exl);
        e_req   = reset && e_take;
        e_stall = hz_stall || (md_use_d && (e_busy || md_start));
        e_pc    = !reset ? 2'd0 : (e_take ? 2'd1 : (eret_m ? 2'd2 : 2'd0));
        check("model_md_busy", 32'(md_busy), 32'(e_busy));
        check("model_exl",     32'(exl),     32'(m_exl));
        check("model_req",     32'(req),     32'(e_req));
        check("model_pc_sel",  32'(pc_sel),  32'(e_pc));
        check("model_f_en",    32'(f_en),    32'(e_req || !e_stall));
        check("model_d_en",    32'(d_en),    32'(e_req || !e_stall));
        check("model_e_clr",   32'(e_clr),   32'(e_stall && !e_req));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        {hz_stall, md_start, md_is_div, md_use_d, exc_req, int_req, eret_m} = '0;
        step();
        step();

        // Reset state, with inputs that must not redirect while in reset.
        exc_req = 1'b1; hz_stall = 1'b1;
        #1;
        check("rst_exl", 32'(exl), 0);
        check("rst_md_busy", 32'(md_busy), 0);
        check("rst_req", 32'(req), 0);
        check("rst_pc_sel", 32'(pc_sel), 0);
        check("rst_f_en", 32'(f_en), 0);
        check("rst_e_clr", 32'(e_clr), 1);
        exc_req = 1'b0; hz_stall = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Mult issue at cycle 0: busy for cycles 1..5, idle at 6.
        md_start = 1'b1; md_is_div = 1'b0;
        #1 check("mult_c0_busy", 32'(md_busy), 0);
        step();
        md_start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1 check($sformatf("mult_c%0d_busy", c), 32'(md_busy), 32'(c <= 5));
            step();
        end

        // Div with D-stage HI/LO use: stalled cycles 0..10, released at 11.
        md_start = 1'b1; md_is_div = 1'b1; md_use_d = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            if (c == 1) md_start = 1'b0;
            #1;
            check($sformatf("div_c%0d_f_en", c), 32'(f_en), 32'(c == 11));
            check($sformatf("div_c%0d_d_en", c), 32'(d_en), 32'(c == 11));
            check($sformatf("div_c%0d_e_clr", c), 32'(e_clr), 32'(c <= 10));
            step();
        end
        md_use_d = 1'b0; md_is_div = 1'b0;

        // Exception beats a hazard stall.
        hz_stall = 1'b1; exc_req = 1'b1;
        #1;
        check("exc_req", 32'(req), 1);
        check("exc_pc_sel", 32'(pc_sel), 1);
        check("exc_f_en", 32'(f_en), 1);
        check("exc_e_clr", 32'(e_clr), 0);
        step();
        hz_stall = 1'b0; exc_req = 1'b0;
        #1 check("exc_exl_after", 32'(exl), 1);

        // Interrupt masked in EXL; ERET returns; pending interrupt then taken.
        int_req = 1'b1;
        #1 check("int_in_exl_req", 32'(req), 0);
        step();
        eret_m = 1'b1;
        #1 check("eret_pc_sel", 32'(pc_sel), 2);
        check("eret_req", 32'(req), 0);
        step();
        eret_m = 1'b0;
        #1 check("eret_exl_after", 32'(exl), 0);
        check("int_taken_req", 32'(req), 1);
        check("int_taken_pc_sel", 32'(pc_sel), 1);
        step();
        int_req = 1'b0;
        #1 check("int_exl_after", 32'(exl), 1);

        // Exception while already in EXL: redirect again, stay in EXL.
        exc_req = 1'b1;
        #1 check("exc_in_exl_req", 32'(req), 1);
        step();
        exc_req = 1'b0;
        #1 check("exc_in_exl_stay", 32'(exl), 1);
        eret_m = 1'b1;
        step();
        #1 check("eret_back_exl", 32'(exl), 0);
        // ERET in NORMAL: EPC select, mode unchanged.
        #1 check("eret_normal_pc_sel", 32'(pc_sel), 2);
        step();
        eret_m = 1'b0;
        #1 check("eret_normal_exl", 32'(exl), 0);

        // Issue during busy at counter 3 is ignored: 2, 1, 0 follow.
        md_start = 1'b1; md_is_div = 1'b0;
        step();
        md_start = 1'b0;
        step();
        step();
        md_start = 1'b1; md_is_div = 1'b1;
        #1 check("reissue_cnt3", 32'(dut.u_md.cnt_q), 3);
        step();
        md_start = 1'b0; md_is_div = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            #1 check($sformatf("reissue_cnt%0d", k), 32'(dut.u_md.cnt_q), 32'(k));
            step();
        end
        #1 check("reissue_idle", 32'(md_busy), 0);

        // Asynchronous reset mid-div (counter 7) while in EXL.
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        md_start = 1'b1; md_is_div = 1'b1;
        step();
        md_start = 1'b0; md_is_div = 1'b0;
        step();
        step();
        step();
        #1 check("arst_pre_cnt7", 32'(dut.u_md.cnt_q), 7);
        check("arst_pre_exl", 32'(exl), 1);
        #1 reset = 1'b0;
        #1;
        check("arst_md_busy", 32'(md_busy), 0);
        check("arst_exl", 32'(exl), 0);
        step();
        reset = 1'b1;
        step();
        step();
        #1 check("post_rst_busy", 32'(md_busy), 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
